// File: rtl/sci_pkg.sv
// sci_pkg: shared constants and state types for the buffered SCI.
// Register map, STATUS/CTRL bit positions and FSM encodings.
package sci_pkg;

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_DIVL   = 3'd2;
    localparam logic [2:0] A_DIVH   = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    localparam int ST_RXNE   = 0;
    localparam int ST_TXNF   = 1;
    localparam int ST_RXOVR  = 2;
    localparam int ST_FERR   = 3;
    localparam int ST_TXIDLE = 4;

    localparam int CT_RXIE = 0;
    localparam int CT_TXIE = 1;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; extra pointer bit separates full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sci_buffered.sv
// sci_buffered: buffered UART peripheral for the MiniS08 I/O window.
// Programmable divisor, rx/tx FIFOs, sticky error flags and level irq.
module sci_buffered
    import sci_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 434
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sel,
    input  logic [2:0] addr,
    input  logic       read,
    input  logic       write,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    logic             rd_acc, wr_acc, rd_q, wr_q, rd_pulse, wr_pulse;
    logic [DIV_W-1:0] div_q, div_d, div_eff;
    logic [15:0]      div16;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic             ovr_set, ferr_set, st_clr;
    logic [7:0]       status, rd_val, hold_q, hold_d;
    logic             tx_push, tx_pop, tx_full, tx_empty, txidle;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_head, rx_head;

    tx_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             txd_q, txd_d, tx_end;

    rx_state_t        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             rx_m_q, rx_s_q, rx_p_q, rx_fall, rx_end;

    assign rd_acc   = sel & read;
    assign wr_acc   = sel & write;
    assign rd_pulse = rd_acc & ~rd_q;
    assign wr_pulse = wr_acc & ~wr_q;

    assign div16   = 16'(div_q);
    assign div_eff = (div_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_q;
    assign st_clr  = wr_pulse && (addr == A_STATUS);
    assign tx_push = wr_pulse && (addr == A_DATA);
    assign rx_pop  = rd_pulse && (addr == A_DATA) && !rx_empty;
    assign txidle  = tx_empty && (tx_state_q == TX_IDLE);

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txf (
        .clk(clk50), .rst(reset), .push_i(tx_push), .pop_i(tx_pop),
        .data_i(din), .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rxf (
        .clk(clk50), .rst(reset), .push_i(rx_push), .pop_i(rx_pop),
        .data_i(rx_sh_q), .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        if (wr_pulse) begin
            unique case (addr)
                A_DIVL:  div_d = DIV_W'({div16[15:8], din});
                A_DIVH:  div_d = DIV_W'({din, div16[7:0]});
                A_CTRL:  ctrl_d = din[1:0];
                default: ;
            endcase
        end
        ovr_d  = ovr_set | (ovr_q & ~(st_clr & din[ST_RXOVR]));
        ferr_d = ferr_set | (ferr_q & ~(st_clr & din[ST_FERR]));
        irq_d  = (ctrl_q[CT_RXIE] & ~rx_empty) | (ctrl_q[CT_TXIE] & txidle);
    end

    always_comb begin
        status            = '0;
        status[ST_RXNE]   = ~rx_empty;
        status[ST_TXNF]   = ~tx_full;
        status[ST_RXOVR]  = ovr_q;
        status[ST_FERR]   = ferr_q;
        status[ST_TXIDLE] = txidle;
        unique case (addr)
            A_STATUS: rd_val = status;
            A_DATA:   rd_val = rx_empty ? 8'h00 : rx_head;
            A_DIVL:   rd_val = div16[7:0];
            A_DIVH:   rd_val = div16[15:8];
            A_CTRL:   rd_val = {6'b0, ctrl_q};
            default:  rd_val = 8'h00;
        endcase
        hold_d = rd_pulse ? rd_val : hold_q;
    end

    // Later cycles of a held read return the value captured on the first.
    assign dout = rd_acc ? (rd_pulse ? rd_val : hold_q) : 8'h00;
    assign irq  = irq_q;
    assign txd  = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_div_d   = tx_div_q;
        tx_pop     = 1'b0;
        tx_end     = (tx_cnt_q == tx_div_q - DIV_W'(1));
        tx_cnt_d   = (tx_state_q == TX_IDLE || tx_end) ?
                     '0 : tx_cnt_q + DIV_W'(1);
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_div_d   = div_eff;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_end) begin
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_d    = tx_head;
                        tx_div_d   = div_eff;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
        endcase
        unique case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_sh_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign rx_fall = rx_p_q & ~rx_s_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_div_d   = rx_div_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        rx_end     = (rx_state_q == RX_START) ?
                     (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1)) :
                     (rx_cnt_q == rx_div_q - DIV_W'(1));
        rx_cnt_d   = (rx_state_q == RX_IDLE || rx_end) ?
                     '0 : rx_cnt_q + DIV_W'(1);
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_div_d   = div_eff;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_end) begin
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_end) begin
                    rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_end) begin
                    rx_state_d = RX_IDLE;
                    if (!rx_s_q)                 ferr_set = 1'b1;
                    else if (rx_full && !rx_pop) ovr_set  = 1'b1;
                    else                         rx_push  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            div_q      <= DIV_W'(DIV_RESET);
            ctrl_q     <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            hold_q     <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_W'(MIN_DIV);
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_W'(MIN_DIV);
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
        end else begin
            rd_q       <= rd_acc;
            wr_q       <= wr_acc;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
            hold_q     <= hold_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_m_q     <= rxd;
            rx_s_q     <= rx_m_q;
            rx_p_q     <= rx_s_q;
        end
    end

endmodule

// File: doc/sci_buffered.md
# sci_buffered

Buffered, parametrised serial communications interface (UART) peripheral for the MiniS08 memory-mapped I/O window. It is the successor to the fixed-rate `sci`. It adds:
- a programmable baud divisor,
- receive and transmit FIFOs of configurable depth,
- sticky error flags,
- an interrupt request output.

It sits on the CPU's `abus`/`dbus` behind an I/O address decode and runs entirely in the `clk50` domain.

## Interface
- `FIFO_DEPTH`, default 8: entries per FIFO. Power of two, minimum 2.
- `DIV_W`, default 16: width of the baud divisor register.
- `DIV_RESET`, default 434: reset divisor, in clk50 cycles per bit (115200 baud at 50 MHz).
- `clk50` input, 1 bit: sole clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `din` input, 8 bits: write data from `dbus`.
- `dout` output, 8 bits: read data, returned to `dbus` by the CPU mux.
- `sel` input, 1 bit: block selected (I/O address decode).
- `addr` input, 3 bits: register offset (`abus[2:0]`).
- `read` input, 1 bit: read strobe.
- `write` input, 1 bit: write strobe.
- `rxd` input, 1 bit: asynchronous serial in, idle high.
- `txd` output, 1 bit: serial out, idle high.
- `irq` output, 1 bit: level interrupt request.

## Operation
- **Access qualification:** an access is `sel & read` or `sel & write`. Strobes may be held for many clk50 cycles, because the CPU clock is slower. Each access acts once, on the first clk50 cycle of its assertion; a rising-edge detect is registered per strobe.
- **Registers:**
  - 0 STATUS, read:
    - bit0 RXNE: rx FIFO not empty.
    - bit1 TXNF: tx FIFO not full.
    - bit2 RXOVR: sticky overrun.
    - bit3 FERR: sticky framing error.
    - bit4 TXIDLE: tx FIFO empty and shifter idle.
    - Other bits read 0.
  - 0 STATUS, write: writing 1 to bit2 or bit3 clears that flag.
  - 1 DATA, read: returns the rx FIFO head and pops it. When the FIFO is empty, returns 0 and does not pop.
  - 1 DATA, write: pushes to the tx FIFO. When the FIFO is full, the write is silently dropped.
  - 2 DIVL / 3 DIVH: baud divisor, low and high bytes. Bits above `DIV_W` are ignored. An effective divisor below 4 is treated as 4.
  - 4 CTRL: bit0 RXIE, bit1 TXIE.
  - 5–7: read 0; writes are ignored.
- **`dout`:** combinational from registered state while `sel & read`, otherwise 0.
- **`irq`:** `RXIE & RXNE | TXIE & TXIDLE`, registered.
- **Transmitter:**
  - States: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - From TX_IDLE with the FIFO non-empty: pop one byte, latch the divisor, go to TX_START.
  - Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly DIV cycles.
  - From TX_STOP: go to TX_START if the FIFO is non-empty (back-to-back frames, no gap), otherwise TX_IDLE.
- **Receiver:**
  - Input path: 2-flop synchroniser on `rxd`. States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - A synchronised falling edge starts the frame. The start bit is re-sampled at DIV/2: if it reads 1, return to RX_IDLE (glitch rejected).
  - Data bits are sampled at bit centres, every DIV cycles. The stop bit is sampled at its centre:
    - stop = 0: set FERR, discard the byte.
    - stop = 1 and FIFO full: set RXOVR, discard the byte; FIFO contents are unchanged.
    - otherwise: push the byte.
  - Return to RX_IDLE immediately after the stop-bit sample.
- **Divisor changes:** a divisor write takes effect at the next frame start in each direction. Frames in flight keep their latched divisor.
- **Simultaneous events:**
  - A push and a pop in the same cycle on the same FIFO are both honoured, including when the FIFO is full (net count unchanged).
  - A flag clear and a flag set in the same cycle: the set wins.

## Timing
- **Reset values:**
  - `txd` = 1, `irq` = 0, `dout` = 0.
  - Divisor = `DIV_RESET`, CTRL = 0.
  - FIFOs empty, flags clear, both FSMs idle.
- **Reset mid-frame:** the frame is aborted, `txd` returns to 1 on the cycle after reset is sampled, and FIFO contents are lost.
- **Write latency:** on a write to DATA with the transmitter idle, `txd` falls 2 clk50 cycles after the first cycle of the write strobe.
- **Receive latency:** RXNE rises 1 cycle after the stop-bit centre sample, plus 2 cycles of synchroniser latency relative to `rxd`.
- **Read side effects:** the pop takes effect at the end of the first strobe cycle. `dout` shows the head value during that first cycle and the next head value afterwards. The CPU samples `dbus` at its own clock edge and sees the popped value only if reads are single-cycle. The integration requirement therefore follows:
  - The CPU integration registers `dout` at the first strobe cycle and holds it for the strobe duration.
  - This holding register is part of this block.

## Structure
- **Package `sci_pkg`:** register offsets, STATUS/CTRL bit indices, tx/rx state enums, minimum divisor constant (4).
- **Sub-module `sync_fifo`:** parametrised by depth and width (8); instantiated twice.
  - Ports: push, pop, data in/out, full, empty.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide so that full and empty are distinguishable.

## Test plan
- **Reset state:** after reset, read STATUS → 0x12; `txd` = 1; `irq` = 0.
- **Single-byte transmit:** write DIV = 8 (DIVL = 0x08, DIVH = 0x00), then write 0x55 to DATA → `txd` goes low 2 cycles later and shows 0,1,0,1,0,1,0,1,0,1 for 8 cycles each. TXIDLE returns 1 after the stop bit.
- **Loopback receive:** tie `rxd` to `txd`, DIV = 8, write 0xA5 then 0x3C → DATA reads return 0xA5, then 0x3C, then 0 with RXNE = 0. No gap between the two tx frames.
- **Overrun:** `FIFO_DEPTH` = 4, receive 5 frames 0x01–0x05 without reading → reads return 0x01–0x04, RXOVR = 1. Writing 0x04 to STATUS clears RXOVR.
- **Framing error and glitch:**
  - Inject a frame with stop bit = 0 → FERR = 1, RXNE stays 0.
  - Inject a 2-cycle low glitch on `rxd` → no frame is received and no flag is set.
- **Held strobes and interrupt:**
  - DATA write strobe held 20 cycles → exactly one byte transmitted.
  - Read strobe held 20 cycles → exactly one pop.
  - RXIE = 1 → `irq` follows RXNE.
